zapper_shot_ctrl: RTL
=====================

Name: zapper_shot_ctrl

Overview:
- Light-gun shot sequencer between the VGA timing block and the pattern generator. Generalises the single trigger-and-detect hit latch to NUM_TARGETS targets.
- On a debounced trigger press it blanks the screen for BLANK_FRAMES frames, then flashes one target per frame. During each target frame it counts photodiode detect cycles and reports which target, if any, was hit.

Parameters:
- NUM_TARGETS, 2, number of targets flashed per shot (1..8)
- BLANK_FRAMES, 1, all-black frames before the first target frame (1..15)
- DETECT_THRESH, 64, detect-high cycles within one frame needed to register a hit (>=1)
- DEBOUNCE_CYCLES, 250000, cycles the synchronised trigger must stay stable before a level change is accepted (>=1)

Ports:
- clk  in  1  pixel clock (PLL output)
- reset  in  1  asynchronous, active-low reset
- trigger  in  1  raw gun trigger, active high, asynchronous
- detect  in  1  raw photodiode output, active high, asynchronous
- frame_start  in  1  one-cycle pulse from the VGA block at the first cycle of vertical blanking
- flash_black  out  1  pattern generator draws the whole screen black
- flash_target  out  NUM_TARGETS  one-hot; pattern generator draws only target i, in white
- busy  out  1  a shot is in progress (any state except IDLE)
- shot_done  out  1  one-cycle pulse when the result is valid
- hit  out  1  last shot hit a target
- hit_idx  out  max(1,$clog2(NUM_TARGETS))  index of the target hit by the last shot

Behaviour:
- Input conditioning:
  - trigger and detect each pass through a 2-flop synchroniser.
  - trigger is then debounced: the debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Press = rising edge of the debounced level.
- Reset values: state IDLE; all counters 0; flash_black=0, flash_target=0, busy=0, shot_done=0, hit=0, hit_idx=0; synchroniser and debounced levels = 0.
- IDLE:
  - On a press, go to ARM.
  - A press that arrives in any other state is ignored.
- ARM:
  - Wait for frame_start.
  - On frame_start, go to BLANK with frame_cnt=0.
  - flash_black=1 from the cycle BLANK is entered.
- BLANK:
  - flash_black=1.
  - On each frame_start, frame_cnt++.
  - When frame_cnt reaches BLANK_FRAMES on a frame_start, go to TARGET with tgt=0 and det_cnt=0.
- TARGET:
  - flash_target = 1<<tgt; flash_black=0.
  - det_cnt counts cycles with synchronised detect high. It saturates at DETECT_THRESH.
  - On frame_start:
    - If det_cnt==DETECT_THRESH: record hit=1, hit_idx=tgt, go to RESULT. The first qualifying target wins and remaining targets are skipped.
    - Else if tgt==NUM_TARGETS-1: record hit=0, go to RESULT.
    - Else: tgt++, det_cnt=0.
  - A detect pulse that occurs on the frame_start cycle itself counts toward the frame that is ending.
- RESULT:
  - Lasts exactly one cycle.
  - shot_done=1; hit and hit_idx are updated on this cycle.
  - Then go to COOLDOWN.
- COOLDOWN:
  - Stay until the debounced trigger is low, then go to IDLE.
  - Holding the trigger therefore never re-fires.
- Output hold: hit and hit_idx hold their value until the next RESULT. When hit=0, hit_idx=0.
- Latency: first target frame starts BLANK_FRAMES+1 frame_start pulses after the press; result comes at most NUM_TARGETS frames after that.
- busy=1 in ARM, BLANK, TARGET, RESULT and COOLDOWN.
- Reset asserted mid-shot: immediate return to reset values. Outputs black/target clear in the same cycle (asynchronous).
- If frame_start is never received, the block waits indefinitely in ARM, BLANK or TARGET. No timeout.

Optional Feature:
- ZAPPER_LAMP_REJECT_EN defined:
  - During BLANK, any synchronised detect-high cycle sets a lamp_seen flag.
  - If lamp_seen is set, RESULT forces hit=0 and hit_idx=0, regardless of target detects.
  - lamp_seen clears on entry to ARM.
- ZAPPER_LAMP_REJECT_EN undefined: detect is ignored outside TARGET, and no lamp_seen register exists.

Decomposition:
- Package zapper_pkg holds:
  - the state enum (IDLE, ARM, BLANK, TARGET, RESULT, COOLDOWN);
  - the hit-index width function.
- One sub-module, zapper_debounce: synchroniser plus stable-count debouncer, parametrised by DEBOUNCE_CYCLES, with output level only. Instantiated for trigger; detect uses a bare 2-flop synchroniser.

Test Plan:
Bench settings: NUM_TARGETS=3, BLANK_FRAMES=1, DETECT_THRESH=4, DEBOUNCE_CYCLES=3, frame_start every 100 cycles.
1. Press held 2 cycles (shorter than the debounce) -> state stays IDLE, busy=0.
2. Press, detect high 5 cycles in the target-1 frame -> flash_target 001 then 010, shot_done pulse, hit=1, hit_idx=1, target 2 never flashed.
3. Press, detect high 3 cycles in each target frame -> all three targets flashed, hit=0, hit_idx=0.
4. Trigger held high after shot_done -> remains in COOLDOWN, busy=1; release for 3+ cycles -> IDLE; a second press starts a new shot.
5. Reset pulled low during the target-0 frame -> flash_target=0 and busy=0 immediately; hit keeps its reset value 0.
6. With ZAPPER_LAMP_REJECT_EN: detect high in the BLANK frame, plus 5 cycles in the target-0 frame -> hit=0, hit_idx=0. Without the macro, the same stimulus -> hit=1, hit_idx=0.

Source files
------------

// File: rtl/zapper_pkg.sv
// Shared types and helpers for the light-gun shot sequencer.
package zapper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLANK,
    TARGET,
    RESULT,
    COOLDOWN
  } shotState_e;

  // A single target still needs a one-bit index port.
  function automatic int hitIdxWidth(input int numTargets);
    return (numTargets > 1) ? $clog2(numTargets) : 1;
  endfunction

endpackage

// File: rtl/zapper_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; only the
// debounced level leaves the block.
module zapper_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] stableCnt_q;
  logic [CW-1:0] stableCnt_d;

  assign stableCnt_d = stableCnt_q + 1'b1;

  // The count tracks consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      stableCnt_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        stableCnt_q <= '0;
      end else if (stableCnt_q == LAST_C) begin
        level_q     <= sync2_q;
        stableCnt_q <= '0;
      end else begin
        stableCnt_q <= stableCnt_d;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/zapper_shot_ctrl.sv
// Light-gun shot sequencer: blank frames, then one flashed target per frame.
// Optional ZAPPER_LAMP_REJECT_EN vetoes a hit if light was seen while blanked.
module zapper_shot_ctrl
  import zapper_pkg::*;
#(
  parameter int NUM_TARGETS     = 2,
  parameter int BLANK_FRAMES    = 1,
  parameter int DETECT_THRESH   = 64,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  trigger,
  input  logic                                  detect,
  input  logic                                  frame_start,
  output logic                                  flash_black,
  output logic [NUM_TARGETS-1:0]                flash_target,
  output logic                                  busy,
  output logic                                  shot_done,
  output logic                                  hit,
  output logic [hitIdxWidth(NUM_TARGETS)-1:0]   hit_idx
);

  localparam int IW = hitIdxWidth(NUM_TARGETS);
  localparam int DW = $clog2(DETECT_THRESH + 1);
  localparam logic [DW-1:0]          THRESH_C     = DW'(DETECT_THRESH);
  localparam logic [3:0]             BLANK_LAST_C = 4'(BLANK_FRAMES - 1);
  localparam logic [IW-1:0]          TGT_LAST_C   = IW'(NUM_TARGETS - 1);
  localparam logic [NUM_TARGETS-1:0] FIRST_TGT_C  = NUM_TARGETS'(1);

  shotState_e             state_q;
  logic [3:0]             frameCnt_q;
  logic [IW-1:0]          tgt_q;
  logic [DW-1:0]          detCnt_q;
  logic [DW-1:0]          detCnt_d;
  logic                   flashBlack_q;
  logic [NUM_TARGETS-1:0] flashTarget_q;
  logic                   busy_q;
  logic                   shotDone_q;
  logic                   hit_q;
  logic [IW-1:0]          hitIdx_q;

  logic trigLevel;
  logic trigPrev_q;
  logic press;
  logic detSync1_q;
  logic detSync2_q;
  logic targetHit;
  logic lampVeto;
  logic hitAccepted;

  zapper_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uTriggerDebounce (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (trigger),
    .level_o (trigLevel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trigPrev_q <= 1'b0;
      detSync1_q <= 1'b0;
      detSync2_q <= 1'b0;
    end else begin
      trigPrev_q <= trigLevel;
      detSync1_q <= detect;
      detSync2_q <= detSync1_q;
    end
  end

  assign press = trigLevel & ~trigPrev_q;

  // Saturating count; a detect on the frame_start cycle still belongs to the ending frame.
  always_comb begin
    detCnt_d = detCnt_q;
    if (detSync2_q && (detCnt_q != THRESH_C)) begin
      detCnt_d = detCnt_q + 1'b1;
    end
  end

  assign targetHit   = (detCnt_d == THRESH_C);
  assign hitAccepted = targetHit & ~lampVeto;

`ifdef ZAPPER_LAMP_REJECT_EN
  logic lampSeen_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lampSeen_q <= 1'b0;
    end else if ((state_q == IDLE) && press) begin
      lampSeen_q <= 1'b0;
    end else if ((state_q == BLANK) && detSync2_q) begin
      lampSeen_q <= 1'b1;
    end
  end

  assign lampVeto = lampSeen_q;
`else
  assign lampVeto = 1'b0;
`endif

  // Outputs are registered alongside the state so they change with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      frameCnt_q    <= '0;
      tgt_q         <= '0;
      detCnt_q      <= '0;
      flashBlack_q  <= 1'b0;
      flashTarget_q <= '0;
      busy_q        <= 1'b0;
      shotDone_q    <= 1'b0;
      hit_q         <= 1'b0;
      hitIdx_q      <= '0;
    end else begin
      shotDone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (press) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          if (frame_start) begin
            state_q      <= BLANK;
            frameCnt_q   <= '0;
            flashBlack_q <= 1'b1;
          end
        end
        BLANK: begin
          if (frame_start) begin
            if (frameCnt_q == BLANK_LAST_C) begin
              state_q       <= TARGET;
              tgt_q         <= '0;
              detCnt_q      <= '0;
              flashBlack_q  <= 1'b0;
              flashTarget_q <= FIRST_TGT_C;
            end else begin
              frameCnt_q <= frameCnt_q + 1'b1;
            end
          end
        end
        TARGET: begin
          detCnt_q <= detCnt_d;
          if (frame_start) begin
            if (targetHit || (tgt_q == TGT_LAST_C)) begin
              state_q       <= RESULT;
              flashTarget_q <= '0;
              shotDone_q    <= 1'b1;
              hit_q         <= hitAccepted;
              hitIdx_q      <= hitAccepted ? tgt_q : '0;
            end else begin
              tgt_q         <= tgt_q + 1'b1;
              detCnt_q      <= '0;
              flashTarget_q <= flashTarget_q << 1;
            end
          end
        end
        RESULT: begin
          state_q <= COOLDOWN;
        end
        COOLDOWN: begin
          if (!trigLevel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign flash_black  = flashBlack_q;
  assign flash_target = flashTarget_q;
  assign busy         = busy_q;
  assign shot_done    = shotDone_q;
  assign hit          = hit_q;
  assign hit_idx      = hitIdx_q;

endmodule
